// File: rtl/amba3_apb_sram_slave_pkg.sv
// Shared types and elaboration helpers for the APB SRAM completer.
//
// Contents:
//   apb_slave_state_e : completer FSM state (IDLE -> WAIT -> READY).
//   data_base()       : byte-offset width for a data bus width.
//                       Returns log2(DATA_SIZE/8) for the legal widths 8/16/32/64.
//                       Returns -1 for any other width.
package pkg_amba3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slave_state_e;

    // Number of byte-offset bits below the word index; -1 flags an illegal width.
    function automatic int data_base(input int data_size);
        case (data_size)
            8:       return 0;
            16:      return 1;
            32:      return 2;
            64:      return 3;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/amba3_apb_sram_slave_if.sv
// AMBA 3 APB bus bundle shared by the requester (master) and completer (slave).
//
// Signals:
//   psel, penable, pwrite, paddr, pwdata : driven by the master.
//   prdata, pready, pslverr              : driven by the slave.
// Clock and reset are not part of the bundle; they stay plain module ports.
interface amba3_apb_if #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDR_SIZE-1:0] paddr;
    logic [DATA_SIZE-1:0] pwdata;
    logic [DATA_SIZE-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/amba3_apb_sram_slave_mem.sv
// Word-addressed storage array behind the APB completer.
//
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational, from raddr)
//
// The array has one synchronous write port and one combinational read port.
// Contents are deliberately not reset.
module amba3_apb_sram_mem #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/amba3_apb_sram_slave.sv
// AMBA 3 APB completer backed by a MEM_DEPTH x DATA_SIZE word SRAM.
//
// Ports:
//   pclk     : APB clock; all logic runs on the rising edge.
//   preset_n : synchronous, active-low reset.
//   bus      : amba3_apb_if.slave carrying the following signals.
//              psel / penable / pwrite / paddr / pwdata are inputs.
//              prdata / pready / pslverr are registered outputs.
//
// Transfer timing:
//   A setup phase sampled at edge T raises pready in cycle T+1+WAIT_CYCLES.
//   pready stays high for exactly one cycle.
//
// Optional build macro AMBA3_APB_SRAM_ERR_EN:
//   Defined:
//     A misaligned or out-of-range access completes with pslverr=1.
//     The write is suppressed and prdata is returned as 0.
//   Undefined:
//     pslverr is tied 0 and the low address bits are ignored.
//     The word index wraps modulo MEM_DEPTH.
module amba3_apb_sram_slave
    import pkg_amba3::*;
#(
    parameter int ADDR_SIZE   = 32,
    parameter int DATA_SIZE   = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       pclk,
    input  logic       preset_n,
    amba3_apb_if.slave bus
);
    localparam int DATA_BASE = data_base(DATA_SIZE);
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int IDX_W     = ADDR_SIZE - DATA_BASE;
    localparam logic [ADDR_SIZE-1:0] LOW_MASK = ADDR_SIZE'((1 << DATA_BASE) - 1);
    localparam logic [3:0]           WAIT_LD  = 4'(WAIT_CYCLES);

    if (DATA_BASE < 0) begin : g_bad_width
        $error("amba3_apb_sram_slave: DATA_SIZE must be 8, 16, 32 or 64");
    end

    apb_slave_state_e     state;
    logic [3:0]           wcnt;
    logic [DATA_SIZE-1:0] prdata_q;
    logic                 pready_q;
    logic                 pslverr_q;

    // Transfer captured in the setup phase.
    logic [AW-1:0]        cap_idx;
    logic                 cap_write;
    logic                 cap_err;
    logic [DATA_SIZE-1:0] cap_wdata;

    // Address decode of the live bus, used in the setup phase.
    logic [IDX_W-1:0]     in_idx;
    logic                 misalign;
    logic                 oor;
    logic                 in_err;

    assign in_idx   = bus.paddr[ADDR_SIZE-1:DATA_BASE];
    assign misalign = |(bus.paddr & LOW_MASK);
    assign oor      = |(in_idx >> AW);

`ifdef AMBA3_APB_SRAM_ERR_EN
    assign in_err = misalign | oor;
`else
    logic unused_err;
    assign in_err     = 1'b0;
    assign unused_err = misalign | oor;
`endif

    wire setup = bus.psel & ~bus.penable;

    // Memory access.
    // The zero-wait path reads from the live address at the setup edge.
    // The wait path reads from the captured address as it enters READY.
    logic [AW-1:0]        rd_idx;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 mem_we;

    assign rd_idx = (state == IDLE) ? in_idx[AW-1:0] : cap_idx;

    // The write lands only at the completing access edge.
    // It is dropped under reset and on errored accesses.
    assign mem_we = preset_n && (state == READY) && bus.psel && bus.penable
                    && cap_write && !cap_err;

    amba3_apb_sram_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_SIZE)
    ) u_mem (
        .clk   (pclk),
        .we    (mem_we),
        .waddr (cap_idx),
        .wdata (cap_wdata),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // Capture datapath: no reset needed, it is qualified by the FSM.
    always_ff @(posedge pclk) begin
        if (state == IDLE && setup) begin
            cap_idx   <= in_idx[AW-1:0];
            cap_write <= bus.pwrite;
            cap_err   <= in_err;
            cap_wdata <= bus.pwdata;
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state     <= IDLE;
            wcnt      <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    // A lone penable without a setup phase falls through here untouched.
                    if (setup) begin
                        if (WAIT_CYCLES == 0) begin
                            state     <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= in_err;
                            if (!bus.pwrite) prdata_q <= in_err ? '0 : rd_data;
                        end else begin
                            wcnt  <= WAIT_LD;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.psel) begin
                        // Master abandoned the transfer; nothing is written.
                        state <= IDLE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                        if (wcnt == 4'd1) begin
                            state     <= READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= cap_err;
                            if (!cap_write) prdata_q <= cap_err ? '0 : rd_data;
                        end
                    end
                end
                READY: begin
                    state     <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prdata  = prdata_q;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
endmodule

// File: doc/amba3_apb_sram_slave.md
Name: amba3_apb_sram_slave

Overview:
- Synthesizable AMBA 3 APB 1.0 completer that sits directly downstream of the APB master VIP on the `amba3_apb_if` bus.
- Backs a word-addressed SRAM of `MEM_DEPTH` entries.
- Inserts a configurable number of wait states via `pready`.
- Flags bad accesses via `pslverr`.
- Serves as the first RTL target for the APB bench, replacing the behavioural slave model.

Parameters:
- ADDR_SIZE, 32, `paddr` width in bits.
- DATA_SIZE, 32, `pwdata`/`prdata` width; must be 8, 16, 32 or 64.
- MEM_DEPTH, 256, number of DATA_SIZE-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 0, wait states inserted per transfer (0..15).

Ports:
- pclk  in  1  APB clock; all logic on posedge.
- preset_n  in  1  reset; synchronous, active-low.
- psel  in  1  slave select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_SIZE  byte address.
- pwdata  in  DATA_SIZE  write data.
- prdata  out  DATA_SIZE  read data; valid while `pready` = 1.
- pready  out  1  transfer-complete strobe.
- pslverr  out  1  error response; valid only while `pready` = 1.

Behaviour:
- Single clock `pclk`; reset `preset_n` is synchronous and active-low. It is sampled on posedge and clears state, counter and all registered outputs.
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, state=IDLE, `wcnt`=0. Memory contents are not reset.
- DATA_BASE = log2(DATA_SIZE/8).
- Word index = `paddr[ADDR_SIZE-1:DATA_BASE]`.
- Misaligned access: `paddr[DATA_BASE-1:0]` != 0.
- Out of range: index ≥ MEM_DEPTH.
- FSM states are IDLE, WAIT and READY. All outputs are registered.
- **IDLE:**
  - On `psel`=1 and `penable`=0 at posedge: capture `paddr`, `pwrite` and `pwdata`.
  - If WAIT_CYCLES=0: go to READY and set `pready`=1 at the same edge.
  - Otherwise: load `wcnt`=WAIT_CYCLES and go to WAIT.
- **WAIT:**
  - Decrement `wcnt` each edge.
  - When `wcnt`==1: go to READY with `pready`=1.
  - If `psel`=0 (master abort): go to IDLE, no memory write.
- **READY:**
  - `pready`=1 for exactly one cycle.
  - At the edge with `psel`&`penable`: complete the transfer, then return to IDLE with `pready`=0.
- Timing: the setup phase at cycle T gives `pready`=1 in cycle T+1+WAIT_CYCLES. Zero-wait gives the minimum 2-cycle transfer.
- Back-to-back transfers: a new setup phase in the cycle following READY is accepted from IDLE with no idle bubble.
- Write: the memory word is updated at the completing READY edge from the captured data.
- Read: `prdata` is loaded from memory at the edge entering READY. It holds its value until the next read completes; writes leave `prdata` unchanged.
- Read-after-write to the same address in consecutive transfers returns the new data.
- `penable`=1 seen in IDLE without a prior setup phase (protocol violation): ignored, no response.
- Reset asserted mid-transfer: return to IDLE next edge, `pready`=0, pending write dropped.

Optional Feature:
- Macro: `AMBA3_APB_SRAM_ERR_EN`.
- Defined:
  - Misaligned or out-of-range access completes with `pslverr`=1 alongside `pready`.
  - The write is suppressed and `prdata`=0.
  - Wait states are still applied.
- Undefined:
  - `pslverr` is tied 0.
  - Low address bits are ignored.
  - Index wraps modulo MEM_DEPTH, so the access always hits memory.

Decomposition:
- Package `pkg_amba3` gets:
  - typedef enum `apb_slave_state_e` {IDLE, WAIT, READY};
  - the width-check constant function for DATA_BASE.
- Sub-module `amba3_apb_sram_mem`:
  - MEM_DEPTH × DATA_SIZE;
  - one synchronous write port;
  - one combinational read port;
  - parameters DEPTH and WIDTH.
- The FSM, counter and error decode stay in the top.

Test Plan:
1. WAIT_CYCLES=0: write 0x0040←0x80003333, then read 0x0040 → `prdata`=0x80003333, `pready` high in the second cycle of each transfer, `pslverr`=0.
2. WAIT_CYCLES=3: write 0x0084←0x04400011 → `pready` rises exactly 4 cycles after setup; a subsequent read returns 0x04400011.
3. Back-to-back: write 0x0018←0x22446688 immediately followed by a read of 0x0018 with no idle → read returns 0x22446688; the two transfers take 4 cycles total at WAIT_CYCLES=0.
4. With `AMBA3_APB_SRAM_ERR_EN`, MEM_DEPTH=256:
   - write 0x0800←0x00040000 → `pslverr`=1 and memory unchanged;
   - read 0x0042 → `pslverr`=1, `prdata`=0.
   - Without the macro, write 0x0400←0xDEADBEEF then read 0x0000 → 0xDEADBEEF (wrap).
5. Assert `preset_n`=0 during WAIT of a write 0x0010←0x11111111 → `pready` stays 0; after reset, a read of 0x0010 returns the prior contents (0x0 if 0x0 was pre-written), not 0x11111111.
6. Random: 500 writes to aligned random in-range addresses with random 0–10 idle ticks, then read all back → every read matches the scoreboard, zero `pslverr`.
